reaction_game_fsm: RTL and testbench

//   Multi-round reaction-time game controller, successor to the single-shot reaction FSM.

---
 rtl/reaction_game_fsm.sv | 132 +++++++++++++
 tb/tb_reaction_game_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reaction_game_fsm.sv
// Multi-round reaction-time game controller: random delay, random LED target,
// per-round latency in ms, session average and a best time kept across sessions.
module reaction_game_fsm #(
    parameter  int MAX_MS     = 2047,
    parameter  int NUM_LEDS   = 18,
    parameter  int NUM_ROUNDS = 4,
    parameter  int TIMEOUT_MS = 1000,
    localparam int MS_W       = $clog2(MAX_MS + 1),
    localparam int RV_W       = $clog2(NUM_LEDS),
    localparam int RND_W      = $clog2(NUM_ROUNDS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                button_pressed,
    input  logic                ms_tick,
    input  logic [MS_W-1:0]     delay_ms,
    input  logic [RV_W-1:0]     random_value,
    output logic [NUM_LEDS-1:0] led_on,
    output logic [MS_W-1:0]     result_ms,
    output logic                result_valid,
    output logic [MS_W-1:0]     best_ms,
    output logic [MS_W-1:0]     avg_ms,
    output logic [RND_W-1:0]    round_idx,
    output logic                false_start,
    output logic                timeout,
    output logic                busy
);
    typedef enum logic [2:0] {IDLE, WAIT, ARMED, SHOW, DONE, FAULT} state_t;

    state_t                 r_state;
    logic                   r_btn_q;
    logic [MS_W-1:0]        r_dly;
    logic [MS_W-1:0]        r_rt;
    logic [MS_W+RND_W-1:0]  r_sum;

    logic                   w_press;
    logic [MS_W-1:0]        w_dly_ld;
    logic [MS_W-1:0]        w_rt_inc;
    logic [RV_W-1:0]        w_tgt;
    logic                   w_last_round;

    assign w_press      = button_pressed & ~r_btn_q;
    assign w_dly_ld     = (delay_ms == '0) ? MS_W'(1) : delay_ms;
    assign w_rt_inc     = (r_rt == MS_W'(MAX_MS)) ? r_rt : r_rt + MS_W'(1);
    // Widen by one bit so an out-of-range index is detectable for any NUM_LEDS.
    assign w_tgt        = ({1'b0, random_value} >= (RV_W+1)'(NUM_LEDS)) ? '0 : random_value;
    assign w_last_round = (round_idx == RND_W'(NUM_ROUNDS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_btn_q      <= 1'b1;
            r_dly        <= '0;
            r_rt         <= '0;
            r_sum        <= '0;
            led_on       <= '0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            best_ms      <= MS_W'(MAX_MS);
            avg_ms       <= '0;
            round_idx    <= '0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_btn_q      <= button_pressed;
            result_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_press) begin
                    r_sum     <= '0;
                    round_idx <= '0;
                    r_dly     <= w_dly_ld;
                    busy      <= 1'b1;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    // A press wins over a same-cycle final tick.
                    if (w_press) begin
                        false_start <= 1'b1;
                        led_on      <= '1;
                        r_state     <= FAULT;
                    end else if (ms_tick) begin
                        if (r_dly == MS_W'(1)) begin
                            led_on  <= NUM_LEDS'(1) << w_tgt;
                            r_rt    <= '0;
                            r_state <= ARMED;
                        end else begin
                            r_dly <= r_dly - MS_W'(1);
                        end
                    end
                end
                ARMED: begin
                    if (w_press) begin
                        result_ms    <= r_rt;
                        result_valid <= 1'b1;
                        best_ms      <= (r_rt < best_ms) ? r_rt : best_ms;
                        r_sum        <= r_sum + {{RND_W{1'b0}}, r_rt};
                        led_on       <= '0;
                        r_state      <= SHOW;
                    end else if (ms_tick) begin
                        r_rt <= w_rt_inc;
                        if (w_rt_inc == MS_W'(TIMEOUT_MS)) begin
                            timeout <= 1'b1;
                            led_on  <= '1;
                            r_state <= FAULT;
                        end
                    end
                end
                SHOW: if (w_press) begin
                    if (w_last_round) begin
                        avg_ms  <= r_sum[MS_W+RND_W-1:RND_W];
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        round_idx <= round_idx + RND_W'(1);
                        r_dly     <= w_dly_ld;
                        r_state   <= WAIT;
                    end
                end
                DONE: if (w_press) r_state <= IDLE;
                FAULT: if (w_press) begin
                    false_start <= 1'b0;
                    timeout     <= 1'b0;
                    led_on      <= '0;
                    busy        <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reaction_game_fsm.sv
// Directed bench for reaction_game_fsm; latencies go through a scoreboard queue
// that is drained whenever result_valid pulses.
module tb_reaction_game_fsm;
    localparam int MS_W  = 11;
    localparam int RV_W  = 5;
    localparam int RND_W = 2;
    localparam int NL    = 18;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              button_pressed = 1'b0;
    logic              ms_tick = 1'b0;
    logic [MS_W-1:0]   delay_ms = '0;
    logic [RV_W-1:0]   random_value = '0;
    logic [NL-1:0]     led_on;
    logic [MS_W-1:0]   result_ms;
    logic              result_valid;
    logic [MS_W-1:0]   best_ms;
    logic [MS_W-1:0]   avg_ms;
    logic [RND_W-1:0]  round_idx;
    logic              false_start;
    logic              timeout;
    logic              busy;

    reaction_game_fsm #(.MAX_MS(2047), .NUM_LEDS(NL), .NUM_ROUNDS(4), .TIMEOUT_MS(60)) dut (
        .clk(clk), .reset(reset), .button_pressed(button_pressed), .ms_tick(ms_tick),
        .delay_ms(delay_ms), .random_value(random_value), .led_on(led_on),
        .result_ms(result_ms), .result_valid(result_valid), .best_ms(best_ms),
        .avg_ms(avg_ms), .round_idx(round_idx), .false_start(false_start),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0, fails = 0, pulses = 0, pushes = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge, scoreboard drained on result_valid.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (result_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) chk("unexpected_valid", 32'(result_valid), 32'd0);
            else chk("result_ms", 32'(result_ms), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            ms_tick = 1'b1; cyc();
            ms_tick = 1'b0; cyc();
        end
    endtask

    task automatic press();
        button_pressed = 1'b1; cyc();
        button_pressed = 1'b0; cyc();
    endtask

    task automatic press_tick();
        button_pressed = 1'b1; ms_tick = 1'b1; cyc();
        button_pressed = 1'b0; ms_tick = 1'b0; cyc();
    endtask

    task automatic expect_rt(input int rt);
        exp_q.push_back(rt);
        pushes++;
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc(); cyc();
        reset = 1'b0; cyc();
    endtask

    initial begin
        int rts[4];
        // Reset state
        cyc(); cyc();
        chk("rst_led", 32'(led_on), 32'd0);
        chk("rst_best", 32'(best_ms), 32'd2047);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result_ms), 32'd0);
        reset = 1'b0; cyc();

        // T1: basic round
        delay_ms = 11'd3; random_value = 5'd5;
        press();
        chk("t1_busy", 32'(busy), 32'd1);
        tick_n(2);
        chk("t1_wait_led", 32'(led_on), 32'd0);
        tick_n(1);
        chk("t1_led", 32'(led_on), 32'h20);
        tick_n(7);
        expect_rt(7);
        press();
        chk("t1_valid_1cyc", 32'(result_valid), 32'd0);
        chk("t1_result", 32'(result_ms), 32'd7);
        chk("t1_best", 32'(best_ms), 32'd7);
        chk("t1_show_led", 32'(led_on), 32'd0);
        do_reset();
        chk("t1_best_cleared", 32'(best_ms), 32'd2047);

        // T4: full session, avg = (10+20+30+41)>>2 = 25
        rts = '{10, 20, 30, 41};
        delay_ms = 11'd2; random_value = 5'd3;
        press();
        for (int r = 0; r < 4; r++) begin
            tick_n(2);
            chk("t4_led", 32'(led_on), 32'h8);
            tick_n(rts[r]);
            expect_rt(rts[r]);
            press();
            chk("t4_round", 32'(round_idx), 32'(r));
            if (r < 3) press();
        end
        chk("t4_show_busy", 32'(busy), 32'd1);
        press();
        chk("t4_avg", 32'(avg_ms), 32'd25);
        chk("t4_best", 32'(best_ms), 32'd10);
        chk("t4_done_busy", 32'(busy), 32'd0);
        press();
        press();
        for (int r = 0; r < 4; r++) begin
            tick_n(2);
            tick_n(50);
            expect_rt(50);
            press();
            if (r < 3) press();
        end
        press();
        chk("t4_avg2", 32'(avg_ms), 32'd50);
        chk("t4_best_kept", 32'(best_ms), 32'd10);
        press();
        chk("t4_idle", 32'(busy), 32'd0);

        // T2: false start
        delay_ms = 11'd5;
        press();
        tick_n(1);
        press();
        chk("t2_false_start", 32'(false_start), 32'd1);
        chk("t2_led", 32'(led_on), 32'h3FFFF);
        chk("t2_timeout", 32'(timeout), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        press();
        chk("t2_cleared", 32'(false_start), 32'd0);
        chk("t2_led_off", 32'(led_on), 32'd0);

        // T3: timeout at 60 ms; delay_ms=0 behaves as 1
        delay_ms = 11'd0;
        press();
        tick_n(1);
        chk("t3_armed", 32'(led_on), 32'h8);
        tick_n(59);
        chk("t3_not_yet", 32'(timeout), 32'd0);
        tick_n(1);
        chk("t3_timeout", 32'(timeout), 32'd1);
        chk("t3_led", 32'(led_on), 32'h3FFFF);
        chk("t3_best", 32'(best_ms), 32'd10);
        press();
        chk("t3_cleared", 32'(timeout), 32'd0);

        // T5: same-cycle press and tick
        delay_ms = 11'd1;
        press();
        tick_n(1);
        tick_n(4);
        expect_rt(4);
        press_tick();
        chk("t5_result", 32'(result_ms), 32'd4);
        chk("t5_best", 32'(best_ms), 32'd4);
        press();
        press_tick();
        chk("t5_false_start", 32'(false_start), 32'd1);
        chk("t5_round_held", 32'(round_idx), 32'd1);
        press();

        // T6: out-of-range target, reset mid-ARMED with button held
        random_value = 5'd20;
        press();
        tick_n(1);
        chk("t6_led", 32'(led_on), 32'h1);
        tick_n(2);
        button_pressed = 1'b1; reset = 1'b1; cyc();
        chk("t6_rst_led", 32'(led_on), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_best", 32'(best_ms), 32'd2047);
        chk("t6_rst_round", 32'(round_idx), 32'd0);
        reset = 1'b0; cyc(); cyc();
        chk("t6_held_no_press", 32'(busy), 32'd0);
        button_pressed = 1'b0; cyc();
        chk("t6_still_idle", 32'(busy), 32'd0);
        press();
        chk("t6_new_press", 32'(busy), 32'd1);

        chk("pulse_count", 32'(pulses), 32'(pushes));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
